// File: rtl/mul_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mul_issue_ctrl
// Brief    : EX-to-multiplier sequencer: operand capture, result word select,
//            flush drain and watchdog. Optional MUL_ZERO_BYPASS_EN skips the
//            multiplier when an operand is zero.
// Revision : 1.0 - initial release
// ============================================================================
module mul_issue_ctrl #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int TAG_W          = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [31:0]      in_x,
    input  logic [31:0]      in_y,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy,
    output logic             err_timeout,
    output logic             mul_req,
    output logic [31:0]      mul_x,
    output logic [31:0]      mul_y,
    output logic             mul_signed,
    input  logic             mul_done,
    input  logic [63:0]      mul_result
);

    localparam int         c_CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_BUSY  = 2'd1;
    localparam logic [1:0] c_DRAIN = 2'd2;
    localparam logic [1:0] c_RESP  = 2'd3;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [c_CNT_W-1:0] r_wait_cnt;
    logic [31:0]        r_x;
    logic [31:0]        r_y;
    logic [TAG_W-1:0]   r_tag;
    logic [1:0]         r_op;
    logic               r_signed;
    logic [31:0]        r_data;
    logic               r_err;
    logic               w_accept;
    logic               w_expired;
    logic               w_timeout;
    logic               w_capture;
    logic               w_zero;

    assign w_accept  = (r_state == c_IDLE) && in_valid && !flush;
    assign w_expired = (r_wait_cnt == c_CNT_W'(TIMEOUT_CYCLES - 1));
    assign w_capture = (r_state == c_BUSY) && mul_done && !flush;
    assign w_zero    = (in_x == 32'd0) || (in_y == 32'd0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Completion beats the watchdog, and the watchdog beats a flush in BUSY.
    always_comb begin
        w_state_nxt = r_state;
        w_timeout   = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (w_accept) begin
`ifdef MUL_ZERO_BYPASS_EN
                    w_state_nxt = w_zero ? c_RESP : c_BUSY;
`else
                    w_state_nxt = c_BUSY;
`endif
                end
            end
            c_BUSY: begin
                if (mul_done) begin
                    w_state_nxt = flush ? c_IDLE : c_RESP;
                end else if (w_expired) begin
                    w_state_nxt = c_IDLE;
                    w_timeout   = 1'b1;
                end else if (flush) begin
                    w_state_nxt = c_DRAIN;
                end
            end
            c_DRAIN: begin
                if (mul_done) begin
                    w_state_nxt = c_IDLE;
                end else if (w_expired) begin
                    w_state_nxt = c_IDLE;
                    w_timeout   = 1'b1;
                end
            end
            c_RESP: begin
                if (flush || out_ready) begin
                    w_state_nxt = c_IDLE;
                end
            end
            default: w_state_nxt = c_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (r_state == c_IDLE);
        busy      = (r_state != c_IDLE);
        out_valid = (r_state == c_RESP);
        mul_req   = (r_state == c_BUSY) || (r_state == c_DRAIN);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_x        <= 32'd0;
            r_y        <= 32'd0;
            r_tag      <= '0;
            r_op       <= 2'd0;
            r_signed   <= 1'b0;
            r_data     <= 32'd0;
            r_err      <= 1'b0;
            r_wait_cnt <= '0;
        end else begin
            r_err <= w_timeout;
            if (w_accept) begin
                r_x        <= in_x;
                r_y        <= in_y;
                r_tag      <= in_tag;
                r_op       <= in_op;
                r_signed   <= (in_op == 2'b00) || (in_op == 2'b01);
                r_wait_cnt <= '0;
`ifdef MUL_ZERO_BYPASS_EN
                if (w_zero) begin
                    r_data <= 32'd0;
                end
`endif
            end else if (mul_req) begin
                r_wait_cnt <= r_wait_cnt + 1'b1;
            end
            // Ops 01/10 want the high word; 00/11 the low word.
            if (w_capture) begin
                r_data <= (r_op[0] ^ r_op[1]) ? mul_result[63:32] : mul_result[31:0];
            end
        end
    end

    assign out_data    = r_data;
    assign out_tag     = r_tag;
    assign err_timeout = r_err;
    assign mul_x       = r_x;
    assign mul_y       = r_y;
    assign mul_signed  = r_signed;

endmodule
`default_nettype wire

// File: tb/tb_mul_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mul_issue_ctrl
// Brief    : Directed bench for mul_issue_ctrl; the multiplier is played by
//            the stimulus tasks (mul_done / mul_result driven by hand).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mul_issue_ctrl;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_op;
    logic [31:0] in_x;
    logic [31:0] in_y;
    logic [4:0]  in_tag;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [4:0]  out_tag;
    logic        busy;
    logic        err_timeout;
    logic        mul_req;
    logic [31:0] mul_x;
    logic [31:0] mul_y;
    logic        mul_signed;
    logic        mul_done;
    logic [63:0] mul_result;

    int n_pass;
    int n_total;

    mul_issue_ctrl #(.TIMEOUT_CYCLES(16), .TAG_W(5)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_x(in_x), .in_y(in_y), .in_tag(in_tag), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_tag(out_tag), .busy(busy), .err_timeout(err_timeout),
        .mul_req(mul_req), .mul_x(mul_x), .mul_y(mul_y),
        .mul_signed(mul_signed), .mul_done(mul_done), .mul_result(mul_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are checked on the falling edge.
    task automatic step();
        @(negedge clk);
    endtask

    task automatic start_op(input logic [1:0] op, input logic [31:0] x,
                            input logic [31:0] y, input logic [4:0] tag);
        in_valid = 1'b1; in_op = op; in_x = x; in_y = y; in_tag = tag;
        step();
        in_valid = 1'b0; in_op = 2'b00; in_x = 32'd0; in_y = 32'd0; in_tag = 5'd0;
    endtask

    task automatic pulse_done(input logic [63:0] res);
        mul_done = 1'b1; mul_result = res;
        step();
        mul_done = 1'b0; mul_result = 64'd0;
    endtask

    task automatic take_result();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        step();
        n_total++; if ({in_ready, out_valid, busy, err_timeout} !== 4'b1000) $display("FAIL reset_flags: got %b expected 1000", {in_ready, out_valid, busy, err_timeout}); else n_pass++;
        n_total++; if ({mul_req, mul_signed} !== 2'b00) $display("FAIL reset_mul_ctl: got %b expected 00", {mul_req, mul_signed}); else n_pass++;
        n_total++; if ({mul_x, mul_y, out_data, out_tag} !== 101'd0) $display("FAIL reset_data: got %h expected 0", {mul_x, mul_y, out_data, out_tag}); else n_pass++;
        reset = 1'b0;
        step();
    endtask

    task automatic test_mulw();
        start_op(2'b00, 32'd3, 32'd5, 5'd7);
        n_total++; if ({mul_req, mul_signed, in_ready, busy} !== 4'b1101) $display("FAIL mulw_issue: got %b expected 1101", {mul_req, mul_signed, in_ready, busy}); else n_pass++;
        n_total++; if ({mul_x, mul_y} !== {32'd3, 32'd5}) $display("FAIL mulw_operands: got %h expected %h", {mul_x, mul_y}, {32'd3, 32'd5}); else n_pass++;
        repeat (3) step();
        n_total++; if (mul_req !== 1'b1) $display("FAIL mulw_req_held: got %b expected 1", mul_req); else n_pass++;
        pulse_done(64'hDEAD_BEEF_0000_000F);
        n_total++; if ({out_valid, mul_req} !== 2'b10) $display("FAIL mulw_resp: got %b expected 10", {out_valid, mul_req}); else n_pass++;
        n_total++; if ({out_data, out_tag} !== {32'h0000_000F, 5'd7}) $display("FAIL mulw_data: got %h/%0d expected 0000000f/7", out_data, out_tag); else n_pass++;
        take_result();
        n_total++; if ({in_ready, out_valid} !== 2'b10) $display("FAIL mulw_release: got %b expected 10", {in_ready, out_valid}); else n_pass++;
    endtask

    task automatic test_word_select();
        start_op(2'b01, 32'hFFFF_FFFF, 32'd2, 5'd3);
        n_total++; if (mul_signed !== 1'b1) $display("FAIL mulh_signed: got %b expected 1", mul_signed); else n_pass++;
        step();
        pulse_done(64'hFFFF_FFFF_FFFF_FFFE);
        n_total++; if (out_data !== 32'hFFFF_FFFF) $display("FAIL mulh_data: got %h expected ffffffff", out_data); else n_pass++;
        take_result();
        start_op(2'b10, 32'hFFFF_FFFF, 32'd2, 5'd4);
        n_total++; if (mul_signed !== 1'b0) $display("FAIL mulhu_signed: got %b expected 0", mul_signed); else n_pass++;
        step();
        pulse_done(64'h0000_0001_FFFF_FFFE);
        n_total++; if ({out_data, out_tag} !== {32'h0000_0001, 5'd4}) $display("FAIL mulhu_data: got %h/%0d expected 00000001/4", out_data, out_tag); else n_pass++;
        take_result();
        start_op(2'b11, 32'd7, 32'd9, 5'd1);
        n_total++; if (mul_signed !== 1'b0) $display("FAIL mulu_signed: got %b expected 0", mul_signed); else n_pass++;
        pulse_done(64'h0000_0001_0000_003F);
        n_total++; if (out_data !== 32'h0000_003F) $display("FAIL mulu_data: got %h expected 0000003f", out_data); else n_pass++;
        take_result();
    endtask

    task automatic test_flush_drain();
        start_op(2'b00, 32'd10, 32'd10, 5'd2);
        step();
        flush = 1'b1; step(); flush = 1'b0;
        n_total++; if ({mul_req, busy, out_valid, in_ready} !== 4'b1100) $display("FAIL drain_enter: got %b expected 1100", {mul_req, busy, out_valid, in_ready}); else n_pass++;
        flush = 1'b1; step(); flush = 1'b0;
        n_total++; if ({mul_req, out_valid} !== 2'b10) $display("FAIL drain_reflush: got %b expected 10", {mul_req, out_valid}); else n_pass++;
        step();
        pulse_done(64'd100);
        n_total++; if ({in_ready, out_valid, mul_req} !== 3'b100) $display("FAIL drain_exit: got %b expected 100", {in_ready, out_valid, mul_req}); else n_pass++;
        step();
        n_total++; if (out_valid !== 1'b0) $display("FAIL drain_no_result: got %b expected 0", out_valid); else n_pass++;
    endtask

    task automatic test_flush_with_done();
        start_op(2'b00, 32'd4, 32'd4, 5'd5);
        step();
        flush = 1'b1;
        pulse_done(64'd16);
        flush = 1'b0;
        n_total++; if ({in_ready, out_valid, mul_req} !== 3'b100) $display("FAIL flush_done: got %b expected 100", {in_ready, out_valid, mul_req}); else n_pass++;
    endtask

    task automatic test_resp_stall();
        start_op(2'b00, 32'd6, 32'd7, 5'd9);
        step();
        pulse_done(64'd42);
        for (int i = 0; i < 5; i++) begin
            n_total++; if ({out_valid, out_data, out_tag} !== {1'b1, 32'h0000_002A, 5'd9}) $display("FAIL stall_hold[%0d]: got %b/%h/%0d expected 1/0000002a/9", i, out_valid, out_data, out_tag); else n_pass++;
            step();
        end
        take_result();
        n_total++; if ({in_ready, out_valid} !== 2'b10) $display("FAIL stall_release: got %b expected 10", {in_ready, out_valid}); else n_pass++;
    endtask

    task automatic test_resp_flush();
        start_op(2'b00, 32'd3, 32'd3, 5'd8);
        pulse_done(64'd9);
        flush = 1'b1; out_ready = 1'b1;
        step();
        flush = 1'b0; out_ready = 1'b0;
        n_total++; if ({in_ready, out_valid} !== 2'b10) $display("FAIL resp_flush: got %b expected 10", {in_ready, out_valid}); else n_pass++;
    endtask

    task automatic test_idle_guards();
        in_valid = 1'b1; flush = 1'b1; in_x = 32'd1; in_y = 32'd1;
        step();
        in_valid = 1'b0; flush = 1'b0; in_x = 32'd0; in_y = 32'd0;
        n_total++; if ({busy, mul_req} !== 2'b00) $display("FAIL accept_with_flush: got %b expected 00", {busy, mul_req}); else n_pass++;
        pulse_done(64'd77);
        n_total++; if ({busy, out_valid} !== 2'b00) $display("FAIL idle_done_ignored: got %b expected 00", {busy, out_valid}); else n_pass++;
    endtask

    task automatic test_zero_operand();
        start_op(2'b00, 32'd0, 32'h0000_1234, 5'd6);
`ifdef MUL_ZERO_BYPASS_EN
        n_total++; if ({out_valid, mul_req, out_data} !== {2'b10, 32'd0}) $display("FAIL zero_bypass: got %b/%b/%h expected 1/0/00000000", out_valid, mul_req, out_data); else n_pass++;
`else
        n_total++; if ({mul_req, out_valid} !== 2'b10) $display("FAIL zero_issue: got %b expected 10", {mul_req, out_valid}); else n_pass++;
        step();
        pulse_done(64'd0);
        n_total++; if ({out_valid, out_data} !== {1'b1, 32'd0}) $display("FAIL zero_result: got %b/%h expected 1/00000000", out_valid, out_data); else n_pass++;
`endif
        take_result();
    endtask

    task automatic test_back_to_back();
        start_op(2'b00, 32'd2, 32'd2, 5'd1);
        pulse_done(64'd4);
        out_ready = 1'b1;
        in_valid = 1'b1; in_op = 2'b00; in_x = 32'h55; in_y = 32'd3; in_tag = 5'd2;
        step();
        out_ready = 1'b0;
        n_total++; if ({in_ready, busy, out_valid} !== 3'b100) $display("FAIL b2b_no_same_cycle: got %b expected 100", {in_ready, busy, out_valid}); else n_pass++;
        step();
        in_valid = 1'b0;
        n_total++; if ({busy, mul_req, mul_x} !== {2'b11, 32'h55}) $display("FAIL b2b_second_accept: got %b/%b/%h expected 1/1/00000055", busy, mul_req, mul_x); else n_pass++;
        pulse_done(64'h0FF);
        n_total++; if ({out_data, out_tag} !== {32'h0000_00FF, 5'd2}) $display("FAIL b2b_second_data: got %h/%0d expected 000000ff/2", out_data, out_tag); else n_pass++;
        take_result();
    endtask

    task automatic test_timeout();
        int seen;
        seen = 0;
        start_op(2'b00, 32'd1, 32'd1, 5'd1);
        for (int c = 1; c <= 40 && seen == 0; c++) begin
            if (err_timeout === 1'b1) seen = c;
            else step();
        end
        n_total++; if (seen !== 17) $display("FAIL timeout_cycle: got %0d expected 17 (0 means no pulse)", seen); else n_pass++;
        n_total++; if ({mul_req, in_ready, out_valid} !== 3'b010) $display("FAIL timeout_state: got %b expected 010", {mul_req, in_ready, out_valid}); else n_pass++;
        step();
        n_total++; if (err_timeout !== 1'b0) $display("FAIL timeout_pulse_width: got %b expected 0", err_timeout); else n_pass++;
    endtask

    task automatic test_reset_mid();
        start_op(2'b01, 32'h1234_5678, 32'd9, 5'd3);
        reset = 1'b1;
        #1;
        n_total++; if ({busy, mul_req, mul_signed, in_ready} !== 4'b0001) $display("FAIL async_reset_ctl: got %b expected 0001", {busy, mul_req, mul_signed, in_ready}); else n_pass++;
        n_total++; if ({mul_x, out_tag} !== 37'd0) $display("FAIL async_reset_data: got %h expected 0", {mul_x, out_tag}); else n_pass++;
        reset = 1'b0;
        step();
    endtask

    initial begin
        n_pass = 0; n_total = 0;
        reset = 1'b1; in_valid = 1'b0; in_op = 2'b00; in_x = 32'd0; in_y = 32'd0;
        in_tag = 5'd0; flush = 1'b0; out_ready = 1'b0; mul_done = 1'b0; mul_result = 64'd0;
        test_reset();
        test_mulw();
        test_word_select();
        test_flush_drain();
        test_flush_with_done();
        test_resp_stall();
        test_resp_flush();
        test_idle_guards();
        test_zero_operand();
        test_back_to_back();
        test_timeout();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
